mb_bus_if: RTL and testbench
============================

MB_BUS_IF -- requirements
Module: mb_bus_if

Interface
REQ-001 SHALL provide parameter NUMBER_INTERFACE_REGS, default 16, total mailbox register slots (one-hot select width).
REQ-002 SHALL provide parameter MB_REG_START, default 3, lowest host-accessible register index.
REQ-003 SHALL provide parameter VERSION_REG_ADDR, default 15, read-only version register index.
REQ-004 SHALL provide parameter ACCESS_CYCLES, default 2, range 1..15, cycles select is held before read data is sampled.
REQ-005 Ports (name  direction  width  meaning); one clock, reset asynchronous active-low:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- host_req  in  1  host transaction request, four-phase handshake.
- host_wr  in  1  1 = write, 0 = read; valid with host_req.
- host_addr  in  4  register index; valid with host_req.
- host_wdata  in  32  write data; valid with host_req.
- host_ack  out  1  transaction complete.
- host_err  out  1  transaction rejected; valid while host_ack = 1.
- host_rdata  out  32  read data; valid while host_ack = 1 on a good read.
- mb_reg_select  out  NUMBER_INTERFACE_REGS  one-hot register select to the mailbox read/write stage.
- mb_reg_rwn  out  1  1 = read, 0 = write, to the mailbox stage.
- mb_reg_wdata  out  32  write data to the mailbox stage.
- mb_reg_output  in  32  muxed read data from the mailbox stage.
- err_count  out  8  saturating count of rejected transactions.

Function
REQ-006 SHALL implement FSM states IDLE, ACCESS, ACK.
REQ-007 IDLE: on a rising edge with host_req = 1, SHALL latch host_wr, host_addr, host_wdata; these latched values SHALL drive all later behaviour of the transaction.
REQ-008 A request SHALL be rejected if addr < MB_REG_START, or addr >= NUMBER_INTERFACE_REGS, or (host_wr = 1 and addr = VERSION_REG_ADDR).
- Rejected: IDLE -> ACK directly; host_err = 1; no select bit asserted; err_count += 1.
REQ-009 Accepted request: IDLE -> ACCESS; access counter loads ACCESS_CYCLES-1.
REQ-010 ACCESS: mb_reg_select SHALL have exactly bit[addr] set; mb_reg_rwn = ~wr; mb_reg_wdata = latched wdata; counter decrements each cycle.
- The state SHALL last exactly ACCESS_CYCLES cycles.
REQ-011 On the last ACCESS cycle (counter = 0), a read SHALL capture mb_reg_output into host_rdata; the FSM then moves to ACK.
- A write SHALL leave host_rdata unchanged.
REQ-012 ACK: mb_reg_select = 0; host_ack = 1.
- FSM SHALL remain in ACK while host_req = 1 and return to IDLE on the first edge with host_req = 0.
- host_ack SHALL deassert in that same cycle.
REQ-013 Latency: host_req sampled at edge N -> ACCESS occupies cycles N+1..N+ACCESS_CYCLES; host_ack = 1 from cycle N+ACCESS_CYCLES+1. A rejected request asserts host_ack from cycle N+1.
REQ-014 A new request SHALL NOT be accepted until IDLE is re-entered; host_req held high across ACK SHALL NOT start a second transaction.
REQ-015 mb_reg_select SHALL be all-zero outside ACCESS; mb_reg_rwn SHALL be 1 outside ACCESS.
REQ-016 host_err SHALL be 0 outside ACK and 0 for accepted transactions.
REQ-017 err_count SHALL saturate at 255; it SHALL NOT wrap.
REQ-018 Changes to host_addr, host_wr or host_wdata after the latching edge SHALL have no effect on the current transaction.

Reset
REQ-019 reset_n = 0 SHALL asynchronously force:
- state = IDLE.
- host_ack = 0, host_err = 0, host_rdata = 0.
- mb_reg_select = 0, mb_reg_rwn = 1, mb_reg_wdata = 0.
- err_count = 0, access counter = 0.
REQ-020 Reset asserted mid-ACCESS SHALL drop mb_reg_select immediately, without waiting for a clock edge.
- The aborted transaction SHALL NOT be acknowledged after reset release.
REQ-021 After reset release, the first edge with host_req = 1 SHALL start a new transaction normally.

Verification
REQ-022 Read: ACCESS_CYCLES = 2, host_req = 1, host_wr = 0, host_addr = 5, mb_reg_output = 32'hCAFE_0005 -> select = 16'h0020 for 2 cycles, rwn = 1, host_ack at N+3, host_rdata = 32'hCAFE_0005, host_err = 0.
REQ-023 Write: host_wr = 1, host_addr = 3, host_wdata = 32'h1234_5678 -> select = 16'h0008, rwn = 0, mb_reg_wdata = 32'h1234_5678 for 2 cycles; ack with err = 0; host_rdata unchanged.
REQ-024 Rejects: read addr = 2, then write addr = 15 -> no select bit ever set, host_ack and host_err both 1 at N+1, err_count = 2.
- Version read: addr 15 read -> accepted, select = 16'h8000.
REQ-025 Handshake: host_req held high 5 cycles after host_ack -> host_ack stays 1 and exactly one ACCESS phase occurs; host_req drops -> host_ack = 0 on the next edge.
REQ-026 Reset mid-ACCESS: reset_n low during the first ACCESS cycle of a read to addr 7 -> select = 0 with no clock edge, host_ack never asserted, err_count = 0.
REQ-027 Saturation: 260 rejected transactions -> err_count = 255.

Source files
------------

// File: rtl/mb_bus_if_if.sv
// Host-side four-phase handshake bus for the mailbox register interface.
//   master : host side, drives host_req/host_wr/host_addr/host_wdata
//   slave  : mailbox interface side, drives host_ack/host_err/host_rdata
interface mb_bus_if_if;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 32;

   logic              host_req;
   logic              host_wr;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_ack;
   logic              host_err;
   logic [DATA_W-1:0] host_rdata;

   modport master (
      output host_req, host_wr, host_addr, host_wdata,
      input  host_ack, host_err, host_rdata
   );

   modport slave (
      input  host_req, host_wr, host_addr, host_wdata,
      output host_ack, host_err, host_rdata
   );
endinterface

// File: rtl/mb_bus_if.sv
// Host-to-mailbox bridge. Takes one four-phase host transaction, checks the
// register index, drives a one-hot select to the mailbox stage for
// ACCESS_CYCLES cycles, then acknowledges (with read data or an error).
//   clk, reset_n   : clock, asynchronous active-low reset
//   host           : host handshake bus (slave side)
//   mb_reg_select  : one-hot register select, live only while accessing
//   mb_reg_rwn     : 1 = read, 0 = write
//   mb_reg_wdata   : write data to the mailbox stage
//   mb_reg_output  : read data from the mailbox stage
//   err_count      : saturating count of rejected transactions
module mb_bus_if #(
   parameter int unsigned NUMBER_INTERFACE_REGS = 16,
   parameter int unsigned MB_REG_START          = 3,
   parameter int unsigned VERSION_REG_ADDR      = 15,
   parameter int unsigned ACCESS_CYCLES         = 2
) (
   input  logic                             clk,
   input  logic                             reset_n,
   mb_bus_if_if.slave                       host,
   output logic [NUMBER_INTERFACE_REGS-1:0] mb_reg_select,
   output logic                             mb_reg_rwn,
   output logic [31:0]                      mb_reg_wdata,
   input  logic [31:0]                      mb_reg_output,
   output logic [7:0]                       err_count
);
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned NREG   = NUMBER_INTERFACE_REGS;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] ACK    = 2'd2;

   logic [1:0]       state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             wr_q, wr_next;
   logic             ack_q, ack_next;
   logic             err_q, err_next;
   logic [31:0]      rdata_q, rdata_next;
   logic [NREG-1:0]  sel_next;
   logic             rwn_next;
   logic [31:0]      wdata_next;
   logic [7:0]       errcnt_next;
   logic             reject_c;

   assign host.host_ack   = ack_q;
   assign host.host_err   = err_q;
   assign host.host_rdata = rdata_q;

   // Index outside the host window, or a write to the read-only version register
   assign reject_c = (32'(host.host_addr) <  MB_REG_START) ||
                     (32'(host.host_addr) >= NREG) ||
                     (host.host_wr && (32'(host.host_addr) == VERSION_REG_ADDR));

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Next-state and next-output logic
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      wr_next     = wr_q;
      ack_next    = ack_q;
      err_next    = err_q;
      rdata_next  = rdata_q;
      sel_next    = mb_reg_select;
      rwn_next    = mb_reg_rwn;
      wdata_next  = mb_reg_wdata;
      errcnt_next = err_count;
      case (state)
         IDLE: begin
            if (host.host_req) begin
               wr_next = host.host_wr;
               if (reject_c) begin
                  state_next = ACK;
                  ack_next   = 1'b1;
                  err_next   = 1'b1;
                  if (err_count != 8'hFF) errcnt_next = err_count + 8'd1;
               end else begin
                  state_next = ACCESS;
                  cnt_next   = CNT_W'(ACCESS_CYCLES - 1);
                  sel_next   = NREG'(1) << host.host_addr;
                  rwn_next   = ~host.host_wr;
                  wdata_next = host.host_wdata;
               end
            end
         end
         ACCESS: begin
            if (cnt == '0) begin
               // Select has been stable ACCESS_CYCLES cycles: sample read data
               state_next = ACK;
               sel_next   = '0;
               rwn_next   = 1'b1;
               ack_next   = 1'b1;
               err_next   = 1'b0;
               if (!wr_q) rdata_next = mb_reg_output;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         ACK: begin
            if (!host.host_req) begin
               state_next = IDLE;
               ack_next   = 1'b0;
               err_next   = 1'b0;
            end
         end
         default: begin
            state_next = IDLE;
            sel_next   = '0;
            rwn_next   = 1'b1;
            ack_next   = 1'b0;
            err_next   = 1'b0;
         end
      endcase
   end

   // Output and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt           <= '0;
         wr_q          <= 1'b0;
         ack_q         <= 1'b0;
         err_q         <= 1'b0;
         rdata_q       <= '0;
         mb_reg_select <= '0;
         mb_reg_rwn    <= 1'b1;
         mb_reg_wdata  <= '0;
         err_count     <= '0;
      end else begin
         cnt           <= cnt_next;
         wr_q          <= wr_next;
         ack_q         <= ack_next;
         err_q         <= err_next;
         rdata_q       <= rdata_next;
         mb_reg_select <= sel_next;
         mb_reg_rwn    <= rwn_next;
         mb_reg_wdata  <= wdata_next;
         err_count     <= errcnt_next;
      end
   end
endmodule

// File: tb/tb_mb_bus_if.sv
// Scoreboard bench for mb_bus_if: the driver pushes expected responses, the
// monitor checks the mailbox side every cycle and pops on each host_ack.
module tb_mb_bus_if;
   localparam int unsigned NREG = 16;
   localparam int unsigned AC   = 2;

   typedef struct {
      logic [15:0] sel;
      logic        rwn;
      logic [31:0] wdata;
      logic        err;
      int          acc;
      int          start;
      logic        chk_rdata;
      logic [31:0] rdata;
      logic [7:0]  errcnt;
   } txn_t;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NREG-1:0]  mb_reg_select;
   logic             mb_reg_rwn;
   logic [31:0]      mb_reg_wdata;
   logic [31:0]      mb_reg_output;
   logic [7:0]       err_count;

   mb_bus_if_if host_bus ();

   mb_bus_if #(
      .NUMBER_INTERFACE_REGS(16),
      .MB_REG_START(3),
      .VERSION_REG_ADDR(15),
      .ACCESS_CYCLES(AC)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .host(host_bus),
      .mb_reg_select(mb_reg_select),
      .mb_reg_rwn(mb_reg_rwn),
      .mb_reg_wdata(mb_reg_wdata),
      .mb_reg_output(mb_reg_output),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   txn_t sb_q[$];
   logic [31:0] last_rdata = 32'h0;
   logic [7:0]  exp_errcnt = 8'h0;

   always @(posedge clk) cyc = cyc + 1;

   // Mailbox stage model: register i reads back as CAFE_0000 + i
   always_comb begin
      mb_reg_output = 32'hDEAD_BEEF;
      for (int i = 0; i < int'(NREG); i++)
         if (mb_reg_select[i]) mb_reg_output = 32'hCAFE_0000 | 32'(i);
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Monitor / scoreboard
   int   acc_cnt  = 0;
   logic ack_prev = 1'b0;
   always @(negedge clk) begin
      if (!reset_n) begin
         acc_cnt  = 0;
         ack_prev = 1'b0;
      end else begin
         if (mb_reg_select != '0) begin
            if (sb_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL sel_unexpected: got %h expected 0000", mb_reg_select);
            end else begin
               chk("sel", 32'(mb_reg_select), 32'(sb_q[0].sel));
               chk("rwn_access", 32'(mb_reg_rwn), 32'(sb_q[0].rwn));
               if (!sb_q[0].rwn) chk("mb_wdata", mb_reg_wdata, sb_q[0].wdata);
               acc_cnt++;
            end
         end else begin
            chk("rwn_idle", 32'(mb_reg_rwn), 32'd1);
         end
         if (!host_bus.host_ack) chk("err_outside_ack", 32'(host_bus.host_err), 32'd0);
         if (host_bus.host_ack && !ack_prev) begin
            if (sb_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL ack_unexpected: got ack=1 expected no ack");
            end else begin
               txn_t t;
               t = sb_q.pop_front();
               chk("err", 32'(host_bus.host_err), 32'(t.err));
               chk("access_cycles", 32'(acc_cnt), 32'(t.acc));
               chk("ack_latency", 32'(cyc - t.start), 32'(t.acc));
               chk("err_count", 32'(err_count), 32'(t.errcnt));
               if (t.chk_rdata) chk("rdata", host_bus.host_rdata, t.rdata);
            end
            acc_cnt = 0;
         end
         ack_prev = host_bus.host_ack;
      end
   end

   task automatic do_txn(input logic wr, input logic [3:0] addr,
                         input logic [31:0] wdata, input int hold);
      txn_t t;
      logic rej;
      int   n;
      rej = (addr < 4'd3) || (wr && addr == 4'd15);
      @(negedge clk);
      host_bus.host_req   = 1'b1;
      host_bus.host_wr    = wr;
      host_bus.host_addr  = addr;
      host_bus.host_wdata = wdata;
      t.start = cyc + 1;
      t.err   = rej;
      t.acc   = rej ? 0 : int'(AC);
      t.sel   = rej ? 16'h0 : (16'h1 << addr);
      t.rwn   = ~wr;
      t.wdata = wdata;
      if (rej) begin
         if (exp_errcnt != 8'hFF) exp_errcnt = exp_errcnt + 8'd1;
         t.chk_rdata = 1'b0;
      end else if (wr) begin
         t.chk_rdata = 1'b1;
      end else begin
         last_rdata  = 32'hCAFE_0000 + 32'(addr);
         t.chk_rdata = 1'b1;
      end
      t.rdata  = last_rdata;
      t.errcnt = exp_errcnt;
      sb_q.push_back(t);
      // Scramble inputs after the latching edge; the transaction must not notice
      @(posedge clk); #1;
      host_bus.host_wr    = ~wr;
      host_bus.host_addr  = ~addr;
      host_bus.host_wdata = ~wdata;
      n = 0;
      while (!host_bus.host_ack && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!host_bus.host_ack) begin
         n_tests++; n_fail++;
         $display("FAIL ack_timeout: got ack=0 expected ack=1 within 50 cycles");
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("ack_hold", 32'(host_bus.host_ack), 32'd1);
      end
      @(negedge clk);
      host_bus.host_req = 1'b0;
      @(posedge clk); #1;
      chk("ack_release", 32'(host_bus.host_ack), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      host_bus.host_req   = 1'b0;
      host_bus.host_wr    = 1'b0;
      host_bus.host_addr  = 4'd0;
      host_bus.host_wdata = 32'h0;
      reset_n = 1'b0;
      #12;
      chk("rst_ack",    32'(host_bus.host_ack), 32'd0);
      chk("rst_err",    32'(host_bus.host_err), 32'd0);
      chk("rst_rdata",  host_bus.host_rdata, 32'h0);
      chk("rst_sel",    32'(mb_reg_select), 32'h0);
      chk("rst_rwn",    32'(mb_reg_rwn), 32'd1);
      chk("rst_wdata",  mb_reg_wdata, 32'h0);
      chk("rst_errcnt", 32'(err_count), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      do_txn(1'b0, 4'd5,  32'h0,         0);   // read addr 5
      do_txn(1'b1, 4'd3,  32'h1234_5678, 0);   // write addr 3, rdata unchanged
      do_txn(1'b0, 4'd2,  32'h0,         0);   // reject: below window
      do_txn(1'b1, 4'd15, 32'hFFFF_0000, 0);   // reject: version write
      chk("err_count_2", 32'(err_count), 32'd2);
      do_txn(1'b0, 4'd15, 32'h0,         0);   // version read accepted
      do_txn(1'b1, 4'd10, 32'hA5A5_5A5A, 1);
      do_txn(1'b0, 4'd10, 32'h0,         0);
      do_txn(1'b0, 4'd4,  32'h0,         5);   // req held across ACK

      // Reset during first ACCESS cycle of a read to addr 7
      @(negedge clk);
      host_bus.host_req  = 1'b1;
      host_bus.host_wr   = 1'b0;
      host_bus.host_addr = 4'd7;
      @(posedge clk); #1;
      chk("abort_sel_pre", 32'(mb_reg_select), 32'h0080);
      reset_n = 1'b0;
      #1;
      chk("abort_sel",    32'(mb_reg_select), 32'h0);
      chk("abort_rwn",    32'(mb_reg_rwn), 32'd1);
      chk("abort_errcnt", 32'(err_count), 32'h0);
      @(negedge clk);
      host_bus.host_req = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      last_rdata = 32'h0;
      exp_errcnt = 8'h0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_ack", 32'(host_bus.host_ack), 32'd0);
      end
      chk("abort_rdata", host_bus.host_rdata, 32'h0);

      do_txn(1'b0, 4'd6, 32'h0, 0);            // first request after reset

      for (int i = 0; i < 260; i++) begin
         if (i % 2 == 0) do_txn(1'b0, 4'(i % 3), 32'h0, 0);
         else            do_txn(1'b1, 4'd15, 32'(i), 0);
      end
      chk("err_count_sat", 32'(err_count), 32'd255);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
